simon_ctrl: RTL
===============

SIMON_CTRL -- requirements
Module: simon_ctrl

Interface
REQ-001 Parameter N_COLOURS, 4, number of colour channels (buttons/LEDs), 2..16.
REQ-002 Parameter ROUND_W, 5, round/index width; MAX_ROUND = 2**ROUND_W - 1.
REQ-003 Parameter SPEED_W, 3, flash speed code width.
REQ-004 Parameter SPEED_INIT, 0, speed code loaded at game start.
REQ-005 Parameter TIMEOUT_PULSES, 8, flasher pulses allowed per player press before loss.
REQ-006 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-007 Port rst_n  in  1  asynchronous, active-low reset.
REQ-008 Ports start_btn in 1 game start; btn in N_COLOURS player presses, single-cycle pulses; result in 1 checker match; pulse in 1 flasher tick.
REQ-009 Ports start, load_colour, load_speed, rst_seedgen, player_turn, flash_clk out 1 each; check_round out ROUND_W; speed out SPEED_W; player_colour out $clog2(N_COLOURS); win, lose out 1.

Function
REQ-010 States: IDLE, SEED, LOAD, SHOW_ON, SHOW_OFF, WAIT_IN, CHECK, ROUND_UP, WIN, LOSE; all outputs registered.
REQ-011 IDLE: rst_seedgen=1; start_btn -> SEED.
REQ-012 SEED: start=1 and load_speed=1 for one cycle, speed=SPEED_INIT, round_len=0 -> LOAD.
REQ-013 LOAD: load_colour=1 for one cycle, round_len+1, idx=0 -> SHOW_ON.
REQ-014 SHOW_ON: flash_clk=1, check_round=idx; on pulse -> SHOW_OFF.
REQ-015 SHOW_OFF: flash_clk=0; on pulse, idx==round_len-1 -> WAIT_IN with idx=0, tmo=0; else idx+1 -> SHOW_ON.
REQ-016 WAIT_IN: player_turn=1, check_round=idx; each pulse increments tmo; tmo reaching TIMEOUT_PULSES -> LOSE.
REQ-017 WAIT_IN, exactly one btn bit set: player_colour=encoded index -> CHECK; more than one bit set -> LOSE; btn and pulse same cycle: btn wins, tmo not incremented.
REQ-018 CHECK (one cycle, result sampled): result=0 -> LOSE; result=1 and idx<round_len-1 -> idx+1, tmo=0, WAIT_IN; idx==round_len-1 and round_len==MAX_ROUND -> WIN; else -> ROUND_UP.
REQ-019 ROUND_UP: speed+1 saturating at 2**SPEED_W-1, load_speed=1 for one cycle -> LOAD.
REQ-020 WIN/LOSE: win/lose held 1; start_btn -> SEED (new game, fresh seed); otherwise hold.
REQ-021 start_btn ignored outside IDLE/WIN/LOSE; btn ignored outside WAIT_IN; pulse ignored in IDLE/SEED/LOAD/CHECK/ROUND_UP/WIN/LOSE.
REQ-022 Latency: btn press to win/lose or next WAIT_IN = 2 cycles.

Reset
REQ-023 rst_n low: state=IDLE immediately; rst_seedgen=1; speed=SPEED_INIT; all other outputs, idx, round_len, tmo = 0.
REQ-024 Reset mid-game abandons the game; no output pulse is emitted on reset release.

Configuration
REQ-025 Macro SIMON_SPEED_RAMP_EN defined: ROUND_UP increments speed per REQ-019.
REQ-026 Macro SIMON_SPEED_RAMP_EN undefined: speed fixed at SPEED_INIT all game; ROUND_UP asserts no load_speed and passes straight to LOAD.

Structure
REQ-027 Package simon_pkg holds state enum simon_state_t and default parameter constants.
REQ-028 Sub-module simon_timeout_ctr: pulse counter with clear and expired flag, instantiated once.

Verification
REQ-029 Reset in SHOW_ON -> state IDLE, rst_seedgen=1, flash_clk=0, speed=SPEED_INIT same cycle.
REQ-030 start_btn, 3 correct rounds (result=1) -> load_colour pulsed 4 times, speed 0->3, player_turn high only in WAIT_IN.
REQ-031 Round 2, CHECK with result=0 -> lose=1, no further load_colour; start_btn -> SEED, round_len=1.
REQ-032 WAIT_IN, 8 pulses, no btn -> lose=1 after 8th pulse; 7 pulses then btn -> CHECK, no loss.
REQ-033 btn=4'b0101 in WAIT_IN -> LOSE; btn and pulse same cycle -> CHECK, tmo unchanged.
REQ-034 ROUND_W=2, all correct -> win=1 after round 3; speed saturates at 7 with SPEED_W=3, stays 0 without SIMON_SPEED_RAMP_EN.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and default parameter values for the Simon game controller.
package simon_pkg;

  localparam int unsigned N_COLOURS_DEF      = 4;
  localparam int unsigned ROUND_W_DEF        = 5;
  localparam int unsigned SPEED_W_DEF        = 3;
  localparam int unsigned SPEED_INIT_DEF     = 0;
  localparam int unsigned TIMEOUT_PULSES_DEF = 8;

  typedef enum logic [3:0] {
    StIdle,
    StSeed,
    StLoad,
    StShowOn,
    StShowOff,
    StWaitIn,
    StCheck,
    StRoundUp,
    StWin,
    StLose
  } simon_state_t;

endpackage

// File: rtl/simon_ctrl_if.sv
// Player/checker/flasher signal bundle for simon_ctrl; slave is the controller side.
interface simon_ctrl_if #(
  parameter int unsigned N_COLOURS = 4,
  parameter int unsigned ROUND_W   = 5,
  parameter int unsigned SPEED_W   = 3
) ();
  localparam int unsigned COL_W = (N_COLOURS > 1) ? $clog2(N_COLOURS) : 1;

  logic                 start_btn;
  logic [N_COLOURS-1:0] btn;
  logic                 result;
  logic                 pulse;
  logic                 start;
  logic                 load_colour;
  logic                 load_speed;
  logic                 rst_seedgen;
  logic                 player_turn;
  logic                 flash_clk;
  logic [ROUND_W-1:0]   check_round;
  logic [SPEED_W-1:0]   speed;
  logic [COL_W-1:0]     player_colour;
  logic                 win;
  logic                 lose;

  modport master (
    output start_btn, btn, result, pulse,
    input  start, load_colour, load_speed, rst_seedgen, player_turn, flash_clk,
    input  check_round, speed, player_colour, win, lose
  );

  modport slave (
    input  start_btn, btn, result, pulse,
    output start, load_colour, load_speed, rst_seedgen, player_turn, flash_clk,
    output check_round, speed, player_colour, win, lose
  );
endinterface

// File: rtl/simon_timeout_ctr.sv
// Saturating pulse counter; o_expire flags the increment that reaches LIMIT.
module simon_timeout_ctr #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);
  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_inc && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/simon_ctrl.sv
// Simon game sequencing FSM. Define SIMON_SPEED_RAMP_EN to raise the flash speed every round.
module simon_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned N_COLOURS      = N_COLOURS_DEF,
  parameter int unsigned ROUND_W        = ROUND_W_DEF,
  parameter int unsigned SPEED_W        = SPEED_W_DEF,
  parameter int unsigned SPEED_INIT     = SPEED_INIT_DEF,
  parameter int unsigned TIMEOUT_PULSES = TIMEOUT_PULSES_DEF
) (
  input logic       clk,
  input logic       rst_n,
  simon_ctrl_if.slave bus
);
  localparam int unsigned        COL_W     = (N_COLOURS > 1) ? $clog2(N_COLOURS) : 1;
  localparam logic [ROUND_W-1:0] MAX_ROUND = '1;
  localparam logic [SPEED_W-1:0] SPEED_MAX = '1;
`ifdef SIMON_SPEED_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  simon_state_t       r_state, w_state_d;
  logic [ROUND_W-1:0] r_idx, w_idx_d, r_len, w_len_d;
  logic [SPEED_W-1:0] r_speed, w_speed_d;
  logic [COL_W-1:0]   r_colour, w_colour_d, w_enc;
  logic r_start, r_load_colour, r_load_speed, r_rst_seedgen, r_player_turn, r_flash_clk;
  logic r_win, r_lose;
  logic w_btn_any, w_btn_one, w_last, w_expire, w_tmo_clr, w_tmo_inc;

  assign w_btn_any = |bus.btn;
  assign w_btn_one = w_btn_any && ((bus.btn & (bus.btn - 1'b1)) == '0);
  assign w_last    = (r_idx == r_len - 1'b1);
  // A press in the same cycle as a pulse takes priority, so the pulse is not counted.
  assign w_tmo_clr = (r_state != StWaitIn);
  assign w_tmo_inc = (r_state == StWaitIn) && bus.pulse && !w_btn_any;

  simon_timeout_ctr #(
    .LIMIT(TIMEOUT_PULSES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_tmo_clr),
    .i_inc   (w_tmo_inc),
    .o_expire(w_expire)
  );

  always_comb begin
    w_enc = '0;
    for (int unsigned i = 0; i < N_COLOURS; i++) begin
      if (bus.btn[i]) w_enc = COL_W'(i);
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_len_d    = r_len;
    w_speed_d  = r_speed;
    w_colour_d = r_colour;
    unique case (r_state)
      StIdle:    if (bus.start_btn) w_state_d = StSeed;
      StSeed: begin
        w_len_d   = '0;
        w_state_d = StLoad;
      end
      StLoad: begin
        w_len_d   = r_len + 1'b1;
        w_idx_d   = '0;
        w_state_d = StShowOn;
      end
      StShowOn:  if (bus.pulse) w_state_d = StShowOff;
      StShowOff: begin
        if (bus.pulse) begin
          if (w_last) begin
            w_idx_d   = '0;
            w_state_d = StWaitIn;
          end else begin
            w_idx_d   = r_idx + 1'b1;
            w_state_d = StShowOn;
          end
        end
      end
      StWaitIn: begin
        if (w_btn_one) begin
          w_colour_d = w_enc;
          w_state_d  = StCheck;
        end else if (w_btn_any || w_expire) begin
          w_state_d = StLose;
        end
      end
      StCheck: begin
        if (!bus.result) begin
          w_state_d = StLose;
        end else if (!w_last) begin
          w_idx_d   = r_idx + 1'b1;
          w_state_d = StWaitIn;
        end else if (r_len == MAX_ROUND) begin
          w_state_d = StWin;
        end else begin
          if (RAMP && (r_speed != SPEED_MAX)) w_speed_d = r_speed + 1'b1;
          w_state_d = StRoundUp;
        end
      end
      StRoundUp: w_state_d = StLoad;
      StWin, StLose: if (bus.start_btn) w_state_d = StSeed;
      default:   w_state_d = StIdle;
    endcase
    if (w_state_d == StSeed) w_speed_d = SPEED_W'(SPEED_INIT);
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_len         <= '0;
      r_speed       <= SPEED_W'(SPEED_INIT);
      r_colour      <= '0;
      r_start       <= 1'b0;
      r_load_colour <= 1'b0;
      r_load_speed  <= 1'b0;
      r_rst_seedgen <= 1'b1;
      r_player_turn <= 1'b0;
      r_flash_clk   <= 1'b0;
      r_win         <= 1'b0;
      r_lose        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_idx         <= w_idx_d;
      r_len         <= w_len_d;
      r_speed       <= w_speed_d;
      r_colour      <= w_colour_d;
      r_start       <= (w_state_d == StSeed);
      r_load_colour <= (w_state_d == StLoad);
      r_load_speed  <= (w_state_d == StSeed) || (RAMP && (w_state_d == StRoundUp));
      r_rst_seedgen <= (w_state_d == StIdle);
      r_player_turn <= (w_state_d == StWaitIn);
      r_flash_clk   <= (w_state_d == StShowOn);
      r_win         <= (w_state_d == StWin);
      r_lose        <= (w_state_d == StLose);
    end
  end

  assign bus.start         = r_start;
  assign bus.load_colour   = r_load_colour;
  assign bus.load_speed    = r_load_speed;
  assign bus.rst_seedgen   = r_rst_seedgen;
  assign bus.player_turn   = r_player_turn;
  assign bus.flash_clk     = r_flash_clk;
  assign bus.check_round   = r_idx;
  assign bus.speed         = r_speed;
  assign bus.player_colour = r_colour;
  assign bus.win           = r_win;
  assign bus.lose          = r_lose;
endmodule
